updown_seq_monitor: RTL and testbench
=====================================

# updown_seq_monitor

Receive-side monitor for the 4-bit auto up/down (bounce) counter stream: it samples the counter output, locks onto the sequence, reports the current count direction, flags turnarounds at the end values, measures run length between turnarounds, and counts sequence errors. It sits beside the counter, on its output bus, in the same clock domain. It gives self-checking on hardware and in simulation without a scoreboard.

## Interface
Parameters:
- WIDTH, 4, counter width; end values are 0 and MAX = 2^WIDTH-1
- CNT_W, 8, width of err_count, the run-step counter and last_run

Ports:
- Clk  in  1  system clock, rising edge
- RST  in  1  synchronous, active-high reset
- cnt_in  in  WIDTH  counter value under observation
- cnt_valid  in  1  cnt_in is a new sample this cycle
- dir  out  1  1 = counting up, 0 = counting down or not locked
- locked  out  1  sequence tracked
- turn_pulse  out  1  one-cycle pulse on a legal turnaround
- err_pulse  out  1  one-cycle pulse on a sequence error while locked
- err_count  out  CNT_W  errors since reset, saturating
- last_run  out  CNT_W  step count of the most recently completed run

## Operation
- States: IDLE (no sample held), ACQ (one sample held in prev), UP, DOWN. locked=1 in UP/DOWN only; dir=1 in UP only.
- Samples are taken only when cnt_valid=1. With cnt_valid=0, all state and outputs hold, except the pulses, which are 0.
- IDLE: on a valid sample, prev<=cnt_in and go to ACQ.
- ACQ:
  - cnt_in==prev+1 and prev!=MAX: go to UP, steps<=1.
  - cnt_in==prev-1 and prev!=0: go to DOWN, steps<=1.
  - Any other value: stay in ACQ, no error counted.
  - prev<=cnt_in in every case.
- UP:
  - prev!=MAX and cnt_in==prev+1: accepted step, steps+1.
  - prev==MAX and cnt_in==MAX-1: turnaround. Go to DOWN, turn_pulse, last_run<=steps, steps<=1.
  - Anything else: error.
- DOWN: mirror of UP.
  - prev!=0 and cnt_in==prev-1: accepted step, steps+1.
  - prev==0 and cnt_in==1: turnaround. Go to UP, turn_pulse, last_run<=steps, steps<=1.
  - Anything else: error.
- Error handling:
  - Triggers: a repeated value, a skip, a wrong direction, or a modular wrap such as 15->0 or 0->15.
  - Actions: err_pulse, err_count+1 (saturating at 2^CNT_W-1), go to ACQ, prev<=cnt_in. steps and last_run are unchanged.
- steps saturates at 2^CNT_W-1. On a clean full-range bounce, last_run = MAX (15 for WIDTH=4).
- Error and turnaround are mutually exclusive per sample; the error check takes priority.

## Timing
- All outputs are registered. Outputs reflect a sample on the cycle after the Clk edge at which cnt_valid=1 is captured (latency 1).
- turn_pulse and err_pulse are high for exactly one cycle per triggering sample. Back-to-back valid samples can produce pulses on consecutive cycles.
- Lock needs 2 valid samples. locked rises 1 cycle after the second sample is captured.
- Reset values: state IDLE, prev=0, steps=0, dir=0, locked=0, turn_pulse=0, err_pulse=0, err_count=0, last_run=0.
- RST=1 wins over cnt_valid=1 in the same cycle. The sample is dropped.
- Reset mid-run: all outputs return to their reset values on the next edge, and reacquisition starts from IDLE.
- No combinational path from inputs to outputs.

## Test plan
- Reset: hold RST=1 for 3 cycles with cnt_valid toggling -> all outputs 0, state IDLE.
- Clean bounce: feed 0,1,…,15,14,…,0,1,… with cnt_valid=1 every cycle.
  - locked=1 one cycle after the sample 1 is captured.
  - turn_pulse fires once after 15->14 and once after 0->1.
  - last_run=15 after the 0->1 turn.
  - err_count stays 0.
- Mid-range lock down: feed 9,8,7 -> dir=0, locked=1 after sample 8. Later, 0->1 sets last_run=9.
- Errors:
  - Skip: in UP, 5->7 -> err_pulse one cycle, err_count=1, locked=0. Then 8 relocks UP.
  - Wrap: in UP, 15->0 -> error, err_count+1.
- Saturation and valid gaps:
  - 300 injected repeats: each error is followed by a relock, and err_count saturates at 255.
  - cnt_valid=0 for 10 cycles mid-run: outputs hold and no pulses occur.
- Reset mid-run: assert RST while in DOWN with err_count=3 and the same-cycle cnt_valid=1 -> all outputs 0 on the next cycle, and the sample is ignored.

Source files
------------

// File: rtl/updown_seq_monitor.sv
// Receive-side monitor for a bounce (auto up/down) counter stream: locks onto the
// sequence, reports direction, flags turnarounds, measures run length and counts errors.
module updown_seq_monitor #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             RST,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             cnt_valid,
    output logic             dir,
    output logic             locked,
    output logic             turn_pulse,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] last_run
);

    // state  | meaning
    // S_IDLE | no sample held yet
    // S_ACQ  | one sample held in prev, direction unknown
    // S_UP   | locked, counting up
    // S_DOWN | locked, counting down
    typedef enum logic [1:0] {S_IDLE, S_ACQ, S_UP, S_DOWN} state_t;

    localparam logic [WIDTH-1:0] VAL_MAX  = '1;
    localparam logic [WIDTH-1:0] VAL_ZERO = '0;
    localparam logic [WIDTH-1:0] VAL_ONE  = WIDTH'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic [CNT_W-1:0] last_run_q, last_run_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             turn_q, turn_d;
    logic             err_q, err_d;

    logic             is_inc;
    logic             is_dec;
    logic             err_hit;
    logic [CNT_W-1:0] steps_inc;

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        steps_d     = steps_q;
        last_run_d  = last_run_q;
        err_count_d = err_count_q;
        turn_d      = 1'b0;
        err_d       = 1'b0;
        err_hit     = 1'b0;

        // The end-value guards keep a modular wrap (15->0, 0->15) from looking like a step
        is_inc    = (prev_q != VAL_MAX)  && (cnt_in == prev_q + VAL_ONE);
        is_dec    = (prev_q != VAL_ZERO) && (cnt_in == prev_q - VAL_ONE);
        steps_inc = (steps_q == CNT_MAX) ? steps_q : steps_q + CNT_ONE;

        if (cnt_valid) begin
            prev_d = cnt_in;
            case (state_q)
                S_IDLE: state_d = S_ACQ;
                S_ACQ: begin
                    if (is_inc) begin
                        state_d = S_UP;
                        steps_d = CNT_ONE;
                    end else if (is_dec) begin
                        state_d = S_DOWN;
                        steps_d = CNT_ONE;
                    end
                end
                S_UP: begin
                    if (is_inc) begin
                        steps_d = steps_inc;
                    end else if (prev_q == VAL_MAX && cnt_in == VAL_MAX - VAL_ONE) begin
                        state_d    = S_DOWN;
                        turn_d     = 1'b1;
                        last_run_d = steps_q;
                        steps_d    = CNT_ONE;
                    end else begin
                        err_hit = 1'b1;
                    end
                end
                S_DOWN: begin
                    if (is_dec) begin
                        steps_d = steps_inc;
                    end else if (prev_q == VAL_ZERO && cnt_in == VAL_ONE) begin
                        state_d    = S_UP;
                        turn_d     = 1'b1;
                        last_run_d = steps_q;
                        steps_d    = CNT_ONE;
                    end else begin
                        err_hit = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // Errors drop lock but keep run statistics; prev already took the new sample
            if (err_hit) begin
                state_d     = S_ACQ;
                err_d       = 1'b1;
                err_count_d = (err_count_q == CNT_MAX) ? err_count_q : err_count_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (RST) begin
            state_q     <= S_IDLE;
            prev_q      <= '0;
            steps_q     <= '0;
            last_run_q  <= '0;
            err_count_q <= '0;
            turn_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            steps_q     <= steps_d;
            last_run_q  <= last_run_d;
            err_count_q <= err_count_d;
            turn_q      <= turn_d;
            err_q       <= err_d;
        end
    end

    assign dir        = (state_q == S_UP);
    assign locked     = (state_q == S_UP) || (state_q == S_DOWN);
    assign turn_pulse = turn_q;
    assign err_pulse  = err_q;
    assign err_count  = err_count_q;
    assign last_run   = last_run_q;

endmodule

// File: tb/tb_updown_seq_monitor.sv
// Directed bench for updown_seq_monitor: a vector table for the main sequences,
// followed by a hand-written error/relock loop that drives err_count to saturation.
module tb_updown_seq_monitor;

    logic       Clk;
    logic       RST;
    logic [3:0] cnt_in;
    logic       cnt_valid;
    logic       dir;
    logic       locked;
    logic       turn_pulse;
    logic       err_pulse;
    logic [7:0] err_count;
    logic [7:0] last_run;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [3:0] cnt;
        logic       dir;
        logic       locked;
        logic       turn;
        logic       err;
        logic [7:0] ec;
        logic [7:0] lr;
    } vec_t;

    vec_t vecs[$];

    updown_seq_monitor #(.WIDTH(4), .CNT_W(8)) dut (
        .Clk        (Clk),
        .RST        (RST),
        .cnt_in     (cnt_in),
        .cnt_valid  (cnt_valid),
        .dir        (dir),
        .locked     (locked),
        .turn_pulse (turn_pulse),
        .err_pulse  (err_pulse),
        .err_count  (err_count),
        .last_run   (last_run)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic add(input logic r, input logic v, input int c,
                       input logic d, input logic l, input logic t, input logic e,
                       input int ec, input int lr);
        vec_t x;
        x.rst = r; x.valid = v; x.cnt = 4'(c);
        x.dir = d; x.locked = l; x.turn = t; x.err = e;
        x.ec = 8'(ec); x.lr = 8'(lr);
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0d expected=%0d", name, idx, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic v, input logic [3:0] c);
        RST       = r;
        cnt_valid = v;
        cnt_in    = c;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_all(input int idx, input logic d, input logic l, input logic t,
                           input logic e, input logic [7:0] ec, input logic [7:0] lr);
        chk("dir", idx, {7'd0, dir}, {7'd0, d});
        chk("locked", idx, {7'd0, locked}, {7'd0, l});
        chk("turn_pulse", idx, {7'd0, turn_pulse}, {7'd0, t});
        chk("err_pulse", idx, {7'd0, err_pulse}, {7'd0, e});
        chk("err_count", idx, err_count, ec);
        chk("last_run", idx, last_run, lr);
    endtask

    initial begin
        int cur;
        int exp_ec;

        RST = 1'b1; cnt_valid = 1'b0; cnt_in = 4'd0;

        // reset held with cnt_valid toggling
        add(1, 0, 0,  0, 0, 0, 0, 0, 0);
        add(1, 1, 5,  0, 0, 0, 0, 0, 0);
        add(1, 0, 9,  0, 0, 0, 0, 0, 0);
        add(1, 1, 7,  0, 0, 0, 0, 0, 0);
        // clean bounce 0..15..0..5
        add(0, 1, 0,  0, 0, 0, 0, 0, 0);
        for (int v = 1; v <= 15; v++) add(0, 1, v, 1, 1, 0, 0, 0, 0);
        add(0, 1, 14, 0, 1, 1, 0, 0, 15);
        for (int v = 13; v >= 0; v--) add(0, 1, v, 0, 1, 0, 0, 0, 15);
        add(0, 1, 1,  1, 1, 1, 0, 0, 15);
        for (int v = 2; v <= 5; v++) add(0, 1, v, 1, 1, 0, 0, 0, 15);
        // skip 5->7, relock on 8
        add(0, 1, 7,  0, 0, 0, 1, 1, 15);
        add(0, 1, 8,  1, 1, 0, 0, 1, 15);
        for (int v = 9; v <= 15; v++) add(0, 1, v, 1, 1, 0, 0, 1, 15);
        // wrap 15->0, relock on 1
        add(0, 1, 0,  0, 0, 0, 1, 2, 15);
        add(0, 1, 1,  1, 1, 0, 0, 2, 15);
        // valid gap: everything holds, no pulses
        for (int k = 0; k < 10; k++) add(0, 0, (k * 7 + 3) % 16, 1, 1, 0, 0, 2, 15);
        // 1->9 is an error, then mid-range down lock 9,8,7..0, turn 0->1 gives run 9
        add(0, 1, 9,  0, 0, 0, 1, 3, 15);
        add(0, 1, 8,  0, 1, 0, 0, 3, 15);
        for (int v = 7; v >= 0; v--) add(0, 1, v, 0, 1, 0, 0, 3, 15);
        add(0, 1, 1,  1, 1, 1, 0, 3, 9);
        for (int v = 2; v <= 15; v++) add(0, 1, v, 1, 1, 0, 0, 3, 9);
        add(0, 1, 14, 0, 1, 1, 0, 3, 15);
        add(0, 1, 13, 0, 1, 0, 0, 3, 15);
        // reset in DOWN with a same-cycle sample of 12 that must be dropped
        add(1, 1, 12, 0, 0, 0, 0, 0, 0);
        add(0, 1, 11, 0, 0, 0, 0, 0, 0);
        add(0, 1, 10, 0, 1, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].valid, vecs[i].cnt);
            chk_all(i, vecs[i].dir, vecs[i].locked, vecs[i].turn, vecs[i].err,
                    vecs[i].ec, vecs[i].lr);
        end

        // 300 repeats, each followed by a relock; DOWN at 10 to start
        cur = 10;
        exp_ec = 0;
        for (int i = 0; i < 300; i++) begin
            apply(1'b0, 1'b1, 4'(cur));
            exp_ec = (exp_ec < 255) ? exp_ec + 1 : 255;
            chk_all(1000 + 2 * i, 0, 0, 0, 1, 8'(exp_ec), 0);
            cur = (cur == 10) ? 11 : 10;
            apply(1'b0, 1'b1, 4'(cur));
            chk_all(1001 + 2 * i, (cur == 11), 1, 0, 0, 8'(exp_ec), 0);
        end
        chk("err_count_saturated", 2000, err_count, 8'd255);

        // one more repeat at saturation, then an idle cycle clears the pulse
        apply(1'b0, 1'b1, 4'(cur));
        chk_all(2001, 0, 0, 0, 1, 8'd255, 0);
        apply(1'b0, 1'b0, 4'(cur));
        chk_all(2002, 0, 0, 0, 0, 8'd255, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
